// File: rtl/ex_stage_if.sv
// EX stage port bundle: pipeline control and ID bus in, MEM/forward/SRAM/HI-LO buses out.
interface ex_stage_if;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_fwd;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [64:0]  hilo_bus;
  logic         stallreq;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_fwd, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, hilo_bus, stallreq
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_fwd, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, hilo_bus, stallreq
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS-style execute stage: ID/EX register, single-cycle ALU, data SRAM request and an
// optional iterative div/divu unit enabled by defining EX_DIV_EN.
module ex_stage (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave ex_if
);

  logic [158:0] id_ex_q, id_ex_d;
  logic         stall_id_ex, stall_next, id_ex_update;

  assign stall_id_ex  = ex_if.stall[2];
  assign stall_next   = ex_if.stall[3];
  // Register changes contents on a load or a bubble; only a full hold keeps it.
  assign id_ex_update = ~stall_id_ex | ~stall_next;

  always_comb begin
    id_ex_d = id_ex_q;
    if (stall_id_ex && !stall_next) begin
      id_ex_d = '0;
    end else if (!stall_id_ex) begin
      id_ex_d = ex_if.id_to_ex_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2, data_ram_wen;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc           = id_ex_q[158:127];
  assign inst         = id_ex_q[126:95];
  assign alu_op       = id_ex_q[94:83];
  assign sel_alu_src1 = id_ex_q[82:80];
  assign sel_alu_src2 = id_ex_q[79:76];
  assign data_ram_en  = id_ex_q[75];
  assign data_ram_wen = id_ex_q[74:71];
  assign rf_we        = id_ex_q[70];
  assign rf_waddr     = id_ex_q[69:65];
  assign sel_rf_res   = id_ex_q[64];
  assign rdata1       = id_ex_q[63:32];
  assign rdata2       = id_ex_q[31:0];

  logic [31:0] src1, src2, imm_sext, imm_zext;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  assign src1 = ({32{sel_alu_src1[0]}} & rdata1) |
                ({32{sel_alu_src1[1]}} & pc) |
                ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_alu_src2[0]}} & rdata2) |
                ({32{sel_alu_src2[1]}} & imm_sext) |
                ({32{sel_alu_src2[2]}} & 32'd8) |
                ({32{sel_alu_src2[3]}} & imm_zext);

  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
  logic [31:0] ex_result;
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sll_res  = src2 << src1[4:0];
  assign srl_res  = src2 >> src1[4:0];
  assign sra_res  = $signed(src2) >>> src1[4:0];
  assign lui_res  = {src2[15:0], 16'b0};

  // alu_op is packed MSB-first: add at bit 11 down to lui at bit 0.
  assign ex_result = ({32{alu_op[11]}} & add_res) |
                     ({32{alu_op[10]}} & sub_res) |
                     ({32{alu_op[9]}}  & slt_res) |
                     ({32{alu_op[8]}}  & sltu_res) |
                     ({32{alu_op[7]}}  & (src1 & src2)) |
                     ({32{alu_op[6]}}  & ~(src1 | src2)) |
                     ({32{alu_op[5]}}  & (src1 | src2)) |
                     ({32{alu_op[4]}}  & (src1 ^ src2)) |
                     ({32{alu_op[3]}}  & sll_res) |
                     ({32{alu_op[2]}}  & srl_res) |
                     ({32{alu_op[1]}}  & sra_res) |
                     ({32{alu_op[0]}}  & lui_res);

  assign ex_if.ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
                                  ex_result};
  assign ex_if.ex_to_id_fwd    = {rf_we, rf_waddr, ex_result};
  assign ex_if.data_sram_en    = data_ram_en;
  assign ex_if.data_sram_wen   = data_ram_wen;
  assign ex_if.data_sram_addr  = ex_result;
  assign ex_if.data_sram_wdata = rdata2;

  logic unused_bits;
  assign unused_bits = ^{inst[31:16], ex_if.stall[5:4], ex_if.stall[1:0], id_ex_update};

`ifdef EX_DIV_EN
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        launched_q, launched_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div, is_signed, launch, fits;
  logic [31:0] dvd_abs, dvs_abs, hi, lo;
  logic [32:0] shifted, diff;

  assign is_div    = (inst[31:26] == 6'h00) && (inst[5:0] == 6'h1A || inst[5:0] == 6'h1B);
  assign is_signed = (inst[5:0] == 6'h1A);
  assign launch    = (state_q == StIdle) && is_div && !launched_q;
  assign dvd_abs   = (is_signed && rdata1[31]) ? 32'd0 - rdata1 : rdata1;
  assign dvs_abs   = (is_signed && rdata2[31]) ? 32'd0 - rdata2 : rdata2;
  // Restoring step: shift the next dividend bit into the partial remainder.
  assign shifted   = {rem_q, quo_q[31]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign fits      = shifted >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          cnt_d = 5'd0;
          dvs_d = dvs_abs;
          if (rdata2 == 32'd0) begin
            // Divide-by-zero result is preloaded so DONE needs no special case.
            state_d = StDone;
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = rdata1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = StRun;
            quo_d   = dvd_abs;
            rem_d   = 32'd0;
            qneg_d  = is_signed & (rdata1[31] ^ rdata2[31]);
            rneg_d  = is_signed & rdata1[31];
          end
        end
      end
      StRun: begin
        rem_d = fits ? diff[31:0] : shifted[31:0];
        quo_d = {quo_q[30:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    launched_d = launched_q;
    if (id_ex_update) launched_d = 1'b0;
    else if (launch)  launched_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      launched_q <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      launched_q <= launched_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
    end
  end

  assign hi             = rneg_q ? 32'd0 - rem_q : rem_q;
  assign lo             = qneg_q ? 32'd0 - quo_q : quo_q;
  assign ex_if.stallreq = launch | (state_q == StRun);
  assign ex_if.hilo_bus = (state_q == StDone) ? {1'b1, hi, lo} : 65'd0;
`else
  assign ex_if.stallreq = 1'b0;
  assign ex_if.hilo_bus = 65'd0;
`endif

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall  in  6  stall vector; Stop=1; stall[2] governs ID/EX register, stall[3] the next stage.
REQ-004 id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
REQ-005 ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-006 ex_to_id_fwd  out  38  {rf_we, rf_waddr[4:0], ex_result[31:0]} forwarding path.
REQ-007 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data SRAM request.
REQ-008 hilo_bus  out  65  {hilo_we, hi[31:0], lo[31:0]}.
REQ-009 stallreq  out  1  divider busy request to stall controller.

Function
REQ-010 ID/EX register SHALL: clear on rst; clear (bubble) when stall[2]=1 and stall[3]=0; load id_to_ex_bus when stall[2]=0; otherwise hold.
REQ-011 src1 SHALL be one-hot select of sel_alu_src1: [0] rdata1, [1] pc, [2] zero-extended inst[10:6]; 0 if none.
REQ-012 src2 SHALL be one-hot select of sel_alu_src2: [0] rdata2, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0]; 0 if none.
REQ-013 alu_op bits [11:0] = add, sub, slt(signed), sltu, and, nor, or, xor, sll, srl, sra, lui; shifts use src2 by src1[4:0]; lui = {src2[15:0],16'b0}; add/sub modulo 2^32, no overflow trap; result 0 if no bit set.
REQ-014 ex_result SHALL be the ALU result, combinational from the ID/EX register (0-cycle latency in EX).
REQ-015 data_sram_en=data_ram_en, data_sram_wen=data_ram_wen, data_sram_addr=ex_result, data_sram_wdata=rdata2.
REQ-016 div (inst[31:26]=0, inst[5:0]=0x1A) and divu (func 0x1B) SHALL use an iterative restoring divider, one quotient bit per cycle.
REQ-017 Divider FSM states IDLE, RUN, DONE: IDLE->RUN on div/divu in EX with launched=0 and divisor!=0; IDLE->DONE if divisor=0; RUN->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-018 launched flag SHALL set on leaving IDLE and clear when the ID/EX register loads or bubbles, preventing relaunch of a held instruction.
REQ-019 stallreq SHALL be 1 in the launch cycle and every RUN cycle, 0 in DONE and IDLE otherwise; nonzero divisor: 33 stall cycles, result in 34th.
REQ-020 div: operate on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign; divu unsigned.
REQ-021 Divisor zero: lo=32'hFFFFFFFF, hi=dividend; one stall cycle.
REQ-022 hilo_we=1 only in DONE, with hi=remainder, lo=quotient; hi/lo=0 when hilo_we=0.

Reset
REQ-023 rst SHALL clear ID/EX register, FSM to IDLE, launched=0; hence all outputs 0 the cycle after rst.
REQ-024 rst during RUN SHALL abort division: no hilo_we, stallreq=0 next cycle.

Configuration
REQ-025 Macro EX_DIV_EN defined: divider per REQ-016..022 present.
REQ-026 EX_DIV_EN undefined: no divider logic; stallreq tied 0; hilo_bus tied 0; div/divu pass through ALU path only.

Verification
REQ-027 ori: rdata1=0x00001234, imm=0x00FF, src1[0], src2[3], op_or -> ex_result=0x000012FF, rf_we forwarded on ex_to_id_fwd same cycle.
REQ-028 div: rdata1=0xFFFFFFF9 (-7), rdata2=2 -> stallreq high 33 cycles, then hilo_we=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 divu: 100/7 -> lo=14, hi=2 in cycle 34; held instruction not relaunched while stall[2]=1.
REQ-030 div by zero: rdata1=5, rdata2=0 -> 1 stall cycle, then lo=0xFFFFFFFF, hi=5.
REQ-031 stall[2]=1, stall[3]=0 with valid sw in ID -> next cycle rf_we=0, data_sram_en=0, data_sram_wen=0.
REQ-032 rst asserted on RUN cycle 10 -> stallreq=0, hilo_we=0 next cycle; subsequent div completes normally.
